stage3: RTL and testbench

- Execute stage of the pipeline; sits directly downstream of the decode stage and consumes its ID/EX-registered outputs.
- Contains:
  - the ALU, with its B operand selected by alusrc;
  - the Z/N condition-flag register;
  - branch/jump resolution;
  - the EX/MEM pipeline buffer that feeds the memory stage.
- All outputs are registered: one-cycle latency.

---
 rtl/stage3_pkg.sv | 14 +
 rtl/stage3_alu.sv | 43 ++++
 rtl/stage3.sv | 125 ++++++++++++
 tb/tb_stage3.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stage3_pkg.sv
// rtl/stage3_pkg.sv - shared execute-stage constants: ALU opcodes and width defaults
package stage3_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int RW_DEFAULT = 6;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_NEG   = 3'b010;
    localparam logic [2:0] ALU_INC   = 3'b011;
    localparam logic [2:0] ALU_PASSA = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

endpackage

// File: rtl/stage3_alu.sv
// rtl/stage3_alu.sv - combinational ALU; signed-overflow output only with STAGE3_OVF_EN
module stage3_alu
    import stage3_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
`ifdef STAGE3_OVF_EN
    output logic          ovf,
`endif
    output logic [DW-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_NEG:   result = '0 - a;
            ALU_INC:   result = a + {{(DW-1){1'b0}}, 1'b1};
            ALU_PASSA: result = a;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

`ifdef STAGE3_OVF_EN
    // Overflow is judged from operand and result sign bits only.
    always_comb begin
        ovf = 1'b0;
        case (op)
            ALU_ADD: ovf = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            ALU_SUB: ovf = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
            ALU_NEG: ovf = a[DW-1] & result[DW-1];
            ALU_INC: ovf = ~a[DW-1] & result[DW-1];
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/stage3.sv
// rtl/stage3.sv - execute stage: ALU, Z/N flags, branch resolution, EX/MEM buffer (optional V flag: STAGE3_OVF_EN)
module stage3
    import stage3_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_imm,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] in_rd1,
    input  logic [DW-1:0] in_rd2,
    input  logic [DW-1:0] in_PC,
    input  logic          in_brz,
    input  logic          in_brn,
    input  logic          in_j,
    input  logic          in_regw,
    input  logic          in_wai,
    input  logic          in_memw,
    input  logic          in_memr,
    input  logic          in_alusrc,
    input  logic [2:0]    in_aluop,
    output logic [DW-1:0] out_alu,
    output logic [DW-1:0] out_wdata,
    output logic [RW-1:0] out_rd,
    output logic [DW-1:0] out_PC,
    output logic          out_regw,
    output logic          out_wai,
    output logic          out_memw,
    output logic          out_memr,
    output logic          out_valid,
    output logic          out_take,
    output logic [DW-1:0] out_target,
`ifdef STAGE3_OVF_EN
    output logic          out_v,
`endif
    output logic          out_z,
    output logic          out_n
);

    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          act;
    logic          fwe;
    logic          take;

    assign alu_b = in_alusrc ? in_imm : in_rd2;
    assign act   = in_valid & ~flush;
    // Loads produce their value in MEM, so they must not touch the flags here.
    assign fwe   = act & in_regw & ~in_memr & ~stall;
    assign take  = act & ~stall & (in_j | (in_brz & out_z) | (in_brn & out_n));

`ifdef STAGE3_OVF_EN
    logic alu_ovf;

    stage3_alu #(.DW(DW)) u_alu (
        .a      (in_rd1),
        .b      (alu_b),
        .op     (in_aluop),
        .ovf    (alu_ovf),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v <= 1'b0;
        end else if (fwe) begin
            out_v <= alu_ovf;
        end
    end
`else
    stage3_alu #(.DW(DW)) u_alu (
        .a      (in_rd1),
        .b      (alu_b),
        .op     (in_aluop),
        .result (alu_result)
    );
`endif

    // Branch decision above reads the pre-edge flags, so a flag-setting branch sees old Z/N.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_z <= 1'b0;
            out_n <= 1'b0;
        end else if (fwe) begin
            out_z <= (alu_result == '0);
            out_n <= alu_result[DW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_alu    <= '0;
            out_wdata  <= '0;
            out_rd     <= '0;
            out_PC     <= '0;
            out_regw   <= 1'b0;
            out_wai    <= 1'b0;
            out_memw   <= 1'b0;
            out_memr   <= 1'b0;
            out_valid  <= 1'b0;
            out_take   <= 1'b0;
            out_target <= '0;
        end else if (stall) begin
            out_take <= 1'b0;
        end else begin
            out_alu    <= alu_result;
            out_wdata  <= in_rd2;
            out_rd     <= in_rd;
            out_PC     <= in_PC;
            out_regw   <= in_regw & act;
            out_wai    <= in_wai & act;
            out_memw   <= in_memw & act;
            out_memr   <= in_memr & act;
            out_valid  <= act;
            out_take   <= take;
            out_target <= in_rd1;
        end
    end

endmodule

// File: tb/tb_stage3.sv
// tb/tb_stage3.sv - directed self-checking bench for stage3 (out_v checks with STAGE3_OVF_EN)
module tb_stage3;
    import stage3_pkg::*;

    localparam int DW = 32;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst, stall, flush, in_valid;
    logic [DW-1:0] in_imm, in_rd1, in_rd2, in_PC;
    logic [RW-1:0] in_rd;
    logic          in_brz, in_brn, in_j, in_regw, in_wai, in_memw, in_memr, in_alusrc;
    logic [2:0]    in_aluop;
    logic [DW-1:0] out_alu, out_wdata, out_PC, out_target;
    logic [RW-1:0] out_rd;
    logic          out_regw, out_wai, out_memw, out_memr, out_valid, out_take, out_z, out_n;
`ifdef STAGE3_OVF_EN
    logic          out_v;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stage3 #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_imm(in_imm), .in_rd(in_rd), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_PC(in_PC),
        .in_brz(in_brz), .in_brn(in_brn), .in_j(in_j), .in_regw(in_regw), .in_wai(in_wai),
        .in_memw(in_memw), .in_memr(in_memr), .in_alusrc(in_alusrc), .in_aluop(in_aluop),
        .out_alu(out_alu), .out_wdata(out_wdata), .out_rd(out_rd), .out_PC(out_PC),
        .out_regw(out_regw), .out_wai(out_wai), .out_memw(out_memw), .out_memr(out_memr),
        .out_valid(out_valid), .out_take(out_take), .out_target(out_target),
`ifdef STAGE3_OVF_EN
        .out_v(out_v),
`endif
        .out_z(out_z), .out_n(out_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; in_valid = 0; in_imm = '0; in_rd = '0; in_rd1 = '0;
        in_rd2 = '0; in_PC = '0; in_brz = 0; in_brn = 0; in_j = 0; in_regw = 0;
        in_wai = 0; in_memw = 0; in_memr = 0; in_alusrc = 0; in_aluop = ALU_ADD;
    endtask

    // Valid instruction: op, A, B/imm, alusrc, regw
    task automatic instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic rw);
        idle();
        in_valid = 1; in_aluop = op; in_rd1 = a; in_alusrc = src; in_regw = rw;
        if (src) in_imm = b; else in_rd2 = b;
    endtask

    initial begin
        idle();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            stall = 1'($urandom); flush = 1'($urandom); in_valid = 1; in_j = 1;
            in_imm = $urandom; in_rd1 = $urandom; in_rd2 = $urandom; in_PC = $urandom;
            in_rd = 6'($urandom); in_regw = 1; in_memw = 1; in_aluop = 3'($urandom);
            step();
        end
        check("rst_alu", out_alu, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_take", {31'b0, out_take}, 0);
        check("rst_target", out_target, 0);
        check("rst_pc", out_PC, 0);
        check("rst_ctrl", {28'b0, out_regw, out_wai, out_memw, out_memr}, 0);
        check("rst_zn", {30'b0, out_z, out_n}, 0);
        rst = 0;

        instr(ALU_ADD, 5, 7, 1, 1); in_rd = 6'd3; in_PC = 32'h100; in_rd2 = 32'hAB;
        step();
        check("add_alu", out_alu, 12);
        check("add_zn", {30'b0, out_z, out_n}, 0);
        check("add_fields", {out_rd, 1'b0, out_valid, out_regw, out_take}, {6'd3, 4'b0110});
        check("add_pc", out_PC, 32'h100);
        check("add_wdata", out_wdata, 32'hAB);

        instr(ALU_SUB, 3, 3, 0, 1);
        step();
        check("sub_alu", out_alu, 0);
        check("sub_z", {30'b0, out_z, out_n}, 2);

        // Flag-setting branch: uses old Z=1, then Z clears.
        instr(ALU_ADD, 32'h20, 1, 1, 1); in_brz = 1;
        step();
        check("fbr_take", {31'b0, out_take}, 1);
        check("fbr_target", out_target, 32'h20);
        check("fbr_alu", out_alu, 32'h21);
        check("fbr_zn", {30'b0, out_z, out_n}, 0);

        instr(ALU_NEG, 1, 0, 0, 1);
        step();
        check("neg_alu", out_alu, 32'hFFFF_FFFF);
        check("neg_zn", {30'b0, out_z, out_n}, 1);
        check("neg_take", {31'b0, out_take}, 0);

        instr(ALU_ADD, 32'h40, 0, 0, 0); in_brn = 1;
        step();
        check("brn_take", {31'b0, out_take}, 1);
        check("brn_target", out_target, 32'h40);

        instr(ALU_ADD, 32'h80, 0, 0, 0); in_brz = 1;
        step();
        check("brz_take", {31'b0, out_take}, 0);

        instr(ALU_ADD, 0, 0, 0, 1); in_memw = 1; in_j = 1; flush = 1;
        step();
        check("flush_valid", {31'b0, out_valid}, 0);
        check("flush_memw", {31'b0, out_memw}, 0);
        check("flush_take", {31'b0, out_take}, 0);
        check("flush_zn", {30'b0, out_z, out_n}, 1);

        instr(ALU_ADD, 0, 0, 0, 1); in_memr = 1;
        step();
        check("load_memr", {31'b0, out_memr}, 1);
        check("load_zn", {30'b0, out_z, out_n}, 1);

        instr(ALU_PASSB, 32'h55, 32'h1234, 1, 0);
        step();
        check("passb_alu", out_alu, 32'h1234);
        instr(3'b110, 32'h55, 32'h1234, 1, 1);
        step();
        check("op6_alu", out_alu, 0);
        check("op6_z", {30'b0, out_z, out_n}, 2);
        instr(ALU_INC, 32'hFFFF_FFFF, 0, 0, 1);
        step();
        check("inc_alu", out_alu, 0);

        instr(ALU_ADD, 4, 5, 1, 1);
        step();
        check("pre_stall_alu", out_alu, 9);
        instr(ALU_ADD, 32'h8000_0000, 0, 1, 1); in_j = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            step();
            check("stall_alu", out_alu, 9);
            check("stall_zn", {30'b0, out_z, out_n}, 0);
            check("stall_take", {31'b0, out_take}, 0);
        end
        stall = 0; flush = 0;
        step();
        check("unstall_alu", out_alu, 32'h8000_0000);
        check("unstall_n", {30'b0, out_z, out_n}, 1);
        check("unstall_take", {31'b0, out_take}, 1);
        check("unstall_target", out_target, 32'h8000_0000);

        stall = 1; rst = 1;
        step();
        check("rst_stall_alu", out_alu, 0);
        check("rst_stall_valid", {31'b0, out_valid}, 0);
        check("rst_stall_zn", {30'b0, out_z, out_n}, 0);
        rst = 0;

`ifdef STAGE3_OVF_EN
        instr(ALU_ADD, 32'h7FFF_FFFF, 1, 1, 1);
        step();
        check("ovf_alu", out_alu, 32'h8000_0000);
        check("ovf_n", {31'b0, out_n}, 1);
        check("ovf_v", {31'b0, out_v}, 1);
        instr(ALU_PASSA, 32'h7FFF_FFFF, 1, 1, 1);
        step();
        check("passa_v", {31'b0, out_v}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
